// File: rtl/cdb_result_queue_pkg.sv
// Common data bus types and constants.
// Shared by the producer queues, the CDB arbiter and reservation-station snoop logic.
package cdb_result_queue_pkg;

    localparam int CDB_DATA_W  = 32;
    localparam int CDB_LABEL_W = 5;

    // Label 0 never names a reservation station; it marks an idle bus.
    localparam logic [CDB_LABEL_W-1:0] NO_LABEL = '0;

    typedef struct packed {
        logic [CDB_LABEL_W-1:0] label;
        logic [CDB_DATA_W-1:0]  data;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_result_queue.sv
// Producer-side CDB endpoint: buffers {data, label} results from a functional unit
// and retires the oldest one each cycle the arbiter grants the bus.
module cdb_result_queue
    import cdb_result_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = CDB_DATA_W,
    parameter int LABEL_W = CDB_LABEL_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [LABEL_W-1:0]       in_label,
    output logic                     in_ready,
    output logic                     cdb_require,
    input  logic                     cdb_accept,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [LABEL_W-1:0]       cdb_label,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0]  data_q  [DEPTH];
    logic [LABEL_W-1:0] label_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push, pop;

    // in_ready looks only at registered occupancy, so a full queue refuses a
    // push even when it pops in the same cycle.
    assign in_ready    = (count_q != FULL_CNT);
    assign cdb_require = (count_q != '0);
    assign push        = in_valid & in_ready;
    // A default grant to an empty queue is ignored.
    assign pop         = cdb_require & cdb_accept;

    assign cdb_data  = cdb_require ? data_q[head_q]  : '0;
    assign cdb_label = cdb_require ? label_q[head_q] : '0;
    assign count     = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; an empty queue masks its outputs to zero.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            data_q[tail_q]  <= in_data;
            label_q[tail_q] <= in_label;
        end
    end

endmodule

// File: tb/tb_cdb_result_queue.sv
// Self-checking bench for cdb_result_queue: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_cdb_result_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_label;
    logic        in_ready;
    logic        cdb_require;
    logic        cdb_accept;
    logic [31:0] cdb_data;
    logic [4:0]  cdb_label;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [4:0]  label;
        logic [31:0] data;
    } ent_t;

    ent_t model[$];

    cdb_result_queue #(.DEPTH(DEPTH), .DATA_W(32), .LABEL_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_label(in_label), .in_ready(in_ready),
        .cdb_require(cdb_require), .cdb_accept(cdb_accept),
        .cdb_data(cdb_data), .cdb_label(cdb_label), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = model.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".require"}, 32'(cdb_require), 32'(n != 0));
        chk({tag, ".ready"}, 32'(in_ready), 32'(n != DEPTH));
        chk({tag, ".data"}, cdb_data, (n != 0) ? model[0].data : 32'h0);
        chk({tag, ".label"}, 32'(cdb_label), (n != 0) ? 32'(model[0].label) : 32'h0);
    endtask

    // One clock: apply inputs, advance the model by the queue's rules, compare after the edge.
    task automatic tick(input string tag, input logic v, input logic [31:0] d,
                        input logic [4:0] l, input logic a, input logic r);
        bit do_push, do_pop;
        in_valid = v; in_data = d; in_label = l; cdb_accept = a; rst = r;
        do_push = v && (model.size() != DEPTH);
        do_pop  = a && (model.size() != 0);
        @(posedge clk);
        #1;
        if (r) model.delete();
        else begin
            if (do_pop) void'(model.pop_front());
            if (do_push) model.push_back({l, d});
        end
        in_valid = 1'b0; cdb_accept = 1'b0; rst = 1'b0;
        check_model(tag);
    endtask

    initial begin
        in_valid = 1'b0; in_data = '0; in_label = '0; cdb_accept = 1'b0; rst = 1'b1;

        // reset and idle with a default grant
        tick("reset", 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        chk("reset.count_const", 32'(count), 32'd0);
        chk("reset.ready_const", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) tick("idle_grant", 1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

        // single result held while the bus is lost
        tick("single_push", 1'b1, 32'h0000_00AA, 5'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick("single_hold", 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
            chk("single_hold.label_const", 32'(cdb_label), 32'd3);
        end
        tick("single_pop", 1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
        chk("single_pop.count_const", 32'(count), 32'd0);

        // fill, refuse, pop, retry
        for (int i = 1; i <= 4; i++) tick("fill", 1'b1, 32'h100 + 32'(i), 5'(i), 1'b0, 1'b0);
        chk("fill.count_const", 32'(count), 32'd4);
        chk("fill.ready_const", 32'(in_ready), 32'd0);
        tick("full_refuse", 1'b1, 32'h105, 5'd5, 1'b0, 1'b0);
        tick("full_pop", 1'b1, 32'h105, 5'd5, 1'b1, 1'b0);
        chk("full_pop.count_const", 32'(count), 32'd3);
        tick("retry_push", 1'b1, 32'h105, 5'd5, 1'b0, 1'b0);
        chk("retry_push.label_const", 32'(cdb_label), 32'd2);
        for (int i = 0; i < 4; i++) tick("drain", 1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

        // streaming across the pointer wrap, push and accept every cycle
        for (int i = 1; i <= 10; i++) begin
            tick("stream", 1'b1, 32'h200 + 32'(i), 5'(i), 1'b1, 1'b0);
            chk("stream.label_const", 32'(cdb_label), 32'(i));
        end
        tick("stream_end", 1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

        // simultaneous push and pop at count 2
        tick("pp_a", 1'b1, 32'h301, 5'd11, 1'b0, 1'b0);
        tick("pp_b", 1'b1, 32'h302, 5'd12, 1'b0, 1'b0);
        tick("pp_both", 1'b1, 32'h303, 5'd13, 1'b1, 1'b0);
        chk("pp_both.count_const", 32'(count), 32'd2);
        chk("pp_both.label_const", 32'(cdb_label), 32'd12);

        // reset with count 3 plus push and accept
        tick("pre_rst", 1'b1, 32'h304, 5'd14, 1'b0, 1'b0);
        tick("mid_rst", 1'b1, 32'h305, 5'd15, 1'b1, 1'b1);
        chk("mid_rst.require_const", 32'(cdb_require), 32'd0);

        // random traffic, labels never zero
        for (int i = 0; i < 400; i++) begin
            tick("random", 1'($urandom_range(0, 1)), $urandom(),
                 5'($urandom_range(1, 31)), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 60) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
